// File: rtl/ir_carrier_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ir_carrier_burst_gen
//  Description : IR LED carrier generator. Drives a 50%-duty square wave at
//                one of three programmable half-periods, either continuously
//                or keyed into bursts of whole carrier periods. Frequency
//                changes and stops land only on period boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module ir_carrier_burst_gen #(
    parameter int HALF_1  = 50000,
    parameter int HALF_2  = 25000,
    parameter int HALF_3  = 16667,
    parameter int CNT_W   = 17,
    parameter int BURST_W = 8
) (
    input  logic               CLK100MHZ,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         freq_sel,
    input  logic               mode,
    input  logic [BURST_W-1:0] burst_on,
    input  logic [BURST_W-1:0] burst_off,
    output logic               ir_out,
    output logic               active,
    output logic               period_tick
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CARRIER = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // position inside the current half
    logic               phase_q, phase_d;   // 0 = first (high) half, 1 = second half
    logic [CNT_W-1:0]   half_q, half_d;     // latched half-period length H
    logic [BURST_W-1:0] pcnt_q, pcnt_d;     // whole periods completed in this state
    logic               ir_out_q, ir_out_d;
    logic               active_q, active_d;
    logic               tick_q, tick_d;

    logic               w_go;
    logic [CNT_W-1:0]   w_half_sel;
    logic               w_last_half;
    logic               w_boundary;
    logic [BURST_W-1:0] w_done;

    assign w_go        = enable & (freq_sel != 2'b00);
    assign w_last_half = (cnt_q == half_q - CNT_W'(1));
    assign w_boundary  = (state_q != IDLE) && w_last_half && phase_q;
    assign w_done      = pcnt_q + BURST_W'(1);

    // Half-period selected by the current freq_sel (00 never gets latched)
    always_comb begin
        case (freq_sel)
            2'b01:   w_half_sel = CNT_W'(HALF_1);
            2'b10:   w_half_sel = CNT_W'(HALF_2);
            default: w_half_sel = CNT_W'(HALF_3);
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            half_q   <= '0;
            pcnt_q   <= '0;
            ir_out_q <= 1'b0;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            half_q   <= half_d;
            pcnt_q   <= pcnt_d;
            ir_out_q <= ir_out_d;
            active_q <= active_d;
            tick_q   <= tick_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so that the
    // registered outputs line up with the registered state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        half_d  = half_q;
        pcnt_d  = pcnt_q;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                pcnt_d  = '0;
                if (w_go) begin
                    half_d  = w_half_sel;
                    // burst_on=0 in burst mode means no carrier at all
                    state_d = (mode && (burst_on == '0)) ? GAP : CARRIER;
                end
            end
            default: begin
                if ((state_q == GAP) && !w_go) begin
                    // Output is already low in a gap, so stop immediately
                    state_d = IDLE;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    pcnt_d  = '0;
                end else if (w_boundary) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    if (!w_go) begin
                        state_d = IDLE;
                        pcnt_d  = '0;
                    end else begin
                        half_d = w_half_sel;
                        if (!mode) begin
                            state_d = CARRIER;
                            pcnt_d  = '0;
                        end else if (burst_on == '0) begin
                            state_d = GAP;
                            pcnt_d  = '0;
                        end else if (burst_off == '0) begin
                            state_d = CARRIER;
                            pcnt_d  = '0;
                        end else if (state_q == CARRIER) begin
                            if (w_done == burst_on) begin
                                state_d = GAP;
                                pcnt_d  = '0;
                            end else begin
                                pcnt_d  = w_done;
                            end
                        end else begin
                            if (w_done == burst_off) begin
                                state_d = CARRIER;
                                pcnt_d  = '0;
                            end else begin
                                pcnt_d  = w_done;
                            end
                        end
                    end
                end else if (w_last_half) begin
                    cnt_d   = '0;
                    phase_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        endcase

        ir_out_d = (state_d == CARRIER) && !phase_d;
        active_d = (state_d != IDLE);
        tick_d   = (state_d != IDLE) && phase_d && (cnt_d == half_d - CNT_W'(1));
    end

    assign ir_out      = ir_out_q;
    assign active      = active_q;
    assign period_tick = tick_q;

endmodule
`default_nettype wire
